// File: rtl/dsram_arbiter.sv
// Data SRAM arbiter: CPU load/store path (default priority) vs. one auxiliary requester.
// Define DSRAM_ARB_STARVE_GUARD_EN to add the bounded-wait starvation guard for the aux port.
module dsram_arbiter #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_en,
    input  logic [3:0]        cpu_wen,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_stallreq,
    input  logic              aux_req,
    input  logic [3:0]        aux_wen,
    input  logic [ADDR_W-1:0] aux_addr,
    input  logic [DATA_W-1:0] aux_wdata,
    output logic              aux_gnt,
    output logic              aux_rvalid,
    output logic [DATA_W-1:0] aux_rdata,
    output logic              data_sram_en,
    output logic [3:0]        data_sram_wen,
    output logic [ADDR_W-1:0] data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata,
    input  logic [DATA_W-1:0] data_sram_rdata
);

    logic force_aux;
    logic aux_win;
    logic aux_rd_pend;

`ifdef DSRAM_ARB_STARVE_GUARD_EN
    localparam logic [3:0] WAIT_LIMIT = 4'(MAX_WAIT);

    logic [3:0] wait_cnt;

    assign force_aux = aux_req && (wait_cnt == WAIT_LIMIT);

    // Counts consecutive lost cycles; any grant or a dropped request restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wait_cnt <= 4'd0;
        end else if (aux_req && !aux_win) begin
            // NOTE: sequential state is updated with non-blocking assignments only.
            if (wait_cnt != WAIT_LIMIT)
                wait_cnt <= wait_cnt + 4'd1;
        end else begin
            wait_cnt <= 4'd0;
        end
    end
`else
    localparam int unused_max_wait = MAX_WAIT;

    assign force_aux = 1'b0;
`endif

    assign aux_win = aux_req && (!cpu_en || force_aux);

    // Grant and stall are gated by reset so nothing reaches the SRAM or pipeline while held.
    assign aux_gnt = rst && aux_win;

`ifdef DSRAM_ARB_STARVE_GUARD_EN
    assign cpu_stallreq = rst && cpu_en && aux_win;
`else
    assign cpu_stallreq = 1'b0;
`endif

    always_comb begin
        // NOTE: every output is given a default first so no path can infer a latch.
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'b0000;
        data_sram_addr  = cpu_addr;
        data_sram_wdata = cpu_wdata;
        if (aux_win) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = aux_wen;
            data_sram_addr  = aux_addr;
            data_sram_wdata = aux_wdata;
        end else if (cpu_en) begin
            data_sram_en    = 1'b1;
            data_sram_wen   = cpu_wen;
        end
        if (!rst) begin
            data_sram_en  = 1'b0;
            data_sram_wen = 4'b0000;
        end
    end

    // Marks that next cycle's SRAM read data belongs to the aux port, not the CPU.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            aux_rd_pend <= 1'b0;
        else
            aux_rd_pend <= aux_win && (aux_wen == 4'b0000);
    end

    assign aux_rvalid = aux_rd_pend;
    assign aux_rdata  = aux_rd_pend ? data_sram_rdata : '0;

endmodule
